// File: rtl/riscv_pkg.sv
// Shared branch-unit definitions: funct3 branch codes, PC-controller FSM encoding and
// the branch-condition decode helper.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SHADOW = 2'd1,
        ST_TRAP   = 2'd2
    } pc_state_t;

    // Funct3 010/011 are not branch encodings and never resolve as taken.
    function automatic logic br_cond(input logic [2:0] funct3,
                                     input logic       less,
                                     input logic       equal);
        logic cond;
        cond = 1'b0;
        case (funct3)
            F3_BEQ:           cond = equal;
            F3_BNE:           cond = ~equal;
            F3_BLT, F3_BLTU:  cond = less;
            F3_BGE, F3_BGEU:  cond = ~less;
            default:          cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/br_target_gen.sv
// Combinational branch resolution: condition decode, redirect request, target address
// and target misalignment detection.
module br_target_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_pc_d,
    input  logic [XLEN-1:0] i_imm_d,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic            i_br_less,
    input  logic            i_br_equal,
    output logic            o_taken,
    output logic            o_jump_req,
    output logic [XLEN-1:0] o_target,
    output logic            o_misaligned
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_reg_rel;

    assign o_taken    = i_is_branch & br_cond(i_funct3, i_br_less, i_br_equal);
    assign o_jump_req = o_taken | i_is_jal | i_is_jalr;

    // Both sums wrap naturally at XLEN bits.
    assign w_pc_rel  = i_pc_d + i_imm_d;
    assign w_reg_rel = (i_rs1_data + i_imm_d) & JALR_MASK;

    assign o_target     = i_is_jalr ? w_reg_rel : w_pc_rel;
    assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/pc_branch_ctrl.sv
// Decode-stage branch resolution and fetch-PC owner with redirect flush and sticky
// misaligned-target trap. Define BRANCH_STATS_EN to add branch/taken statistics counters.
module pc_branch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32,
    parameter int          STAT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_valid_d,
    input  logic              i_is_branch,
    input  logic              i_is_jal,
    input  logic              i_is_jalr,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_pc_d,
    input  logic [XLEN-1:0]   i_imm_d,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic              i_br_less,
    input  logic              i_br_equal,
    output logic              o_br_un,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_pc_plus4,
    output logic              o_flush_fd,
    output logic              o_trap,
    output logic [XLEN-1:0]   o_trap_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] o_br_count,
    output logic [STAT_W-1:0] o_taken_count
`endif
);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_trap;
    logic [XLEN-1:0] r_trap_pc;

    logic            w_taken;
    logic            w_jump_req;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_redirect;

    br_target_gen #(.XLEN(XLEN)) u_target (
        .i_is_branch  (i_is_branch),
        .i_is_jal     (i_is_jal),
        .i_is_jalr    (i_is_jalr),
        .i_funct3     (i_funct3),
        .i_pc_d       (i_pc_d),
        .i_imm_d      (i_imm_d),
        .i_rs1_data   (i_rs1_data),
        .i_br_less    (i_br_less),
        .i_br_equal   (i_br_equal),
        .o_taken      (w_taken),
        .o_jump_req   (w_jump_req),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    assign w_pc_plus4 = r_pc + XLEN'(4);
    // Only RUN may redirect: in SHADOW the decode slot holds the squashed bubble.
    assign w_redirect = i_valid_d & ~i_stall & (r_state == ST_RUN) & w_jump_req;

    assign o_br_un    = i_funct3[1];
    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_flush_fd = w_redirect | (r_state == ST_TRAP);
    assign o_trap     = r_trap;
    assign o_trap_pc  = r_trap_pc;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC[XLEN-1:0];
            r_trap    <= 1'b0;
            r_trap_pc <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!i_stall) begin
                        if (w_redirect && w_misaligned) begin
                            r_state   <= ST_TRAP;
                            r_trap    <= 1'b1;
                            r_trap_pc <= w_target;
                        end else if (w_redirect) begin
                            r_pc    <= w_target;
                            r_state <= ST_SHADOW;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                ST_SHADOW: begin
                    if (!i_stall) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= ST_RUN;
                    end
                end
                ST_TRAP: begin
                    r_trap <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_taken_count;
    logic              w_br_resolved;

    assign w_br_resolved = i_valid_d & ~i_stall & (r_state == ST_RUN) & i_is_branch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (w_br_resolved) begin
            r_br_count <= r_br_count + STAT_W'(1);
            if (w_taken) begin
                r_taken_count <= r_taken_count + STAT_W'(1);
            end
        end
    end

    assign o_br_count    = r_br_count;
    assign o_taken_count = r_taken_count;
`endif

endmodule
